// File: rtl/saes_core_ctrl.sv
// saes_core_ctrl
// Iterative S-AES encrypt/decrypt engine. A 16-bit block, its key and a mode
// bit are captured on a valid/ready handshake. The round keys come from a
// combinational key schedule fed by the captured key. The block is processed
// one round per cycle (AddKey0, Round1, Round2). The result is then held on
// an output handshake until the consumer takes it.
//
// Parameters
//   KEY_REG    1: round keys are latched in an extra KEYX cycle.
//              0: round keys are used straight from the key schedule.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RST        asynchronous reset, active-high
//   In_Valid   block/key/mode offered by the host
//   In_Ready   controller can accept (IDLE, or DONE while Out_Ready is high)
//   Mode       0 = encrypt, 1 = decrypt, captured with the block
//   Data_In    plaintext (encrypt) or ciphertext (decrypt)
//   Key        16-bit cipher key, captured with the block
//   Out_Valid  Data_Out holds a finished result (high exactly in DONE)
//   Out_Ready  consumer takes the result
//   Data_Out   registered result, stable while Out_Valid is high
//   Busy       high in every state except IDLE
module saes_core_ctrl #(
  parameter bit KEY_REG = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic        Mode,
  input  logic [15:0] Data_In,
  input  logic [15:0] Key,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [15:0] Data_Out,
  output logic        Busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYX,
    ST_R0,
    ST_R1,
    ST_R2,
    ST_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] key_q;
  logic [15:0] s_q;
  logic [15:0] s_next;
  logic        mode_q;
  logic        accept;

  logic [7:0]  w2;
  logic [7:0]  w3;
  logic [7:0]  w4;
  logic [7:0]  w5;
  logic [15:0] exp_k0;
  logic [15:0] exp_k1;
  logic [15:0] exp_k2;
  logic [15:0] rk0;
  logic [15:0] rk1;
  logic [15:0] rk2;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'hB;
      4'h4: y = 4'hD;  4'h5: y = 4'h1;  4'h6: y = 4'h8;  4'h7: y = 4'h5;
      4'h8: y = 4'h6;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'h3;
      4'hC: y = 4'hC;  4'hD: y = 4'hE;  4'hE: y = 4'hF;  default: y = 4'h7;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hA;  4'h1: y = 4'h5;  4'h2: y = 4'h9;  4'h3: y = 4'hB;
      4'h4: y = 4'h1;  4'h5: y = 4'h7;  4'h6: y = 4'h8;  4'h7: y = 4'hF;
      4'h8: y = 4'h6;  4'h9: y = 4'h0;  4'hA: y = 4'h2;  4'hB: y = 4'h3;
      4'hC: y = 4'hC;  4'hD: y = 4'h4;  4'hE: y = 4'hD;  default: y = 4'hE;
    endcase
    return y;
  endfunction

  function automatic logic [15:0] sub_nib(input logic [15:0] s);
    return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
  endfunction

  function automatic logic [15:0] sub_nib_inv(input logic [15:0] s);
    return {sbox_inv(s[15:12]), sbox_inv(s[11:8]), sbox_inv(s[7:4]), sbox_inv(s[3:0])};
  endfunction

  // Nibble 0 is bits 15:12; swapping nibbles 1 and 3 is its own inverse.
  function automatic logic [15:0] shift_rows(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  // Multiply by x in GF(2^4), reducing by x^4+x+1.
  function automatic logic [3:0] gf_mul2(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gf_mul4(input logic [3:0] x);
    return gf_mul2(gf_mul2(x));
  endfunction

  function automatic logic [3:0] gf_mul9(input logic [3:0] x);
    return gf_mul2(gf_mul4(x)) ^ x;
  endfunction

  // Columns are (n0,n1) and (n2,n3); forward matrix [1 4; 4 1].
  function automatic logic [15:0] mix_col(input logic [15:0] s);
    return {s[15:12] ^ gf_mul4(s[11:8]), gf_mul4(s[15:12]) ^ s[11:8],
            s[7:4] ^ gf_mul4(s[3:0]),    gf_mul4(s[7:4]) ^ s[3:0]};
  endfunction

  // Inverse matrix [9 2; 2 9].
  function automatic logic [15:0] mix_col_inv(input logic [15:0] s);
    return {gf_mul9(s[15:12]) ^ gf_mul2(s[11:8]), gf_mul2(s[15:12]) ^ gf_mul9(s[11:8]),
            gf_mul9(s[7:4]) ^ gf_mul2(s[3:0]),    gf_mul2(s[7:4]) ^ gf_mul9(s[3:0])};
  endfunction

  // Key schedule: each new word pair is built from the previous pair, using a
  // nibble-rotated, substituted copy of the last word plus a round constant.
  assign w2     = key_q[15:8] ^ 8'h80 ^ {sbox(key_q[3:0]), sbox(key_q[7:4])};
  assign w3     = w2 ^ key_q[7:0];
  assign w4     = w2 ^ 8'h30 ^ {sbox(w3[3:0]), sbox(w3[7:4])};
  assign w5     = w4 ^ w3;
  assign exp_k0 = key_q;
  assign exp_k1 = {w2, w3};
  assign exp_k2 = {w4, w5};

  // The registered option breaks the key-schedule path out of the round
  // datapath at the cost of one cycle per block.
  generate
    if (KEY_REG) begin : g_key_reg
      logic [15:0] k0_q;
      logic [15:0] k1_q;
      logic [15:0] k2_q;

      // Round keys are latched once per block, while the FSM sits in KEYX.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          k0_q <= 16'h0000;
          k1_q <= 16'h0000;
          k2_q <= 16'h0000;
        end else if (state == ST_KEYX) begin
          k0_q <= exp_k0;
          k1_q <= exp_k1;
          k2_q <= exp_k2;
        end
      end

      assign rk0 = k0_q;
      assign rk1 = k1_q;
      assign rk2 = k2_q;
    end else begin : g_key_comb
      assign rk0 = exp_k0;
      assign rk1 = exp_k1;
      assign rk2 = exp_k2;
    end
  endgenerate

  // A new block can be taken in DONE only when the held result leaves on the
  // same edge, so no result is ever overwritten.
  assign In_Ready  = (state == ST_IDLE) | ((state == ST_DONE) & Out_Ready);
  assign accept    = In_Valid & In_Ready;
  assign Out_Valid = (state == ST_DONE);
  assign Busy      = (state != ST_IDLE);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: the round states advance unconditionally. IDLE and DONE
  // wait on the handshakes. An accept always enters the first processing state.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (In_Valid) begin
          if (KEY_REG) state_next = ST_KEYX;
          else         state_next = ST_R0;
        end
      end
      ST_KEYX: state_next = ST_R0;
      ST_R0:   state_next = ST_R1;
      ST_R1:   state_next = ST_R2;
      ST_R2:   state_next = ST_DONE;
      ST_DONE: begin
        if (Out_Ready) begin
          if (!In_Valid)    state_next = ST_IDLE;
          else if (KEY_REG) state_next = ST_KEYX;
          else              state_next = ST_R0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Round datapath. Decryption runs the inverse steps in reverse order with
  // the round keys applied K2, K1, K0.
  always_comb begin
    s_next = s_q;
    case (state)
      ST_R0: s_next = s_q ^ (mode_q ? rk2 : rk0);
      ST_R1: begin
        if (mode_q) s_next = mix_col_inv(sub_nib_inv(shift_rows(s_q)) ^ rk1);
        else        s_next = mix_col(shift_rows(sub_nib(s_q))) ^ rk1;
      end
      ST_R2: begin
        if (mode_q) s_next = sub_nib_inv(shift_rows(s_q)) ^ rk0;
        else        s_next = shift_rows(sub_nib(s_q)) ^ rk2;
      end
      default: s_next = s_q;
    endcase
  end

  // Block, key and mode are captured only on accept, so host inputs are free
  // to change afterwards. Data_Out updates only on the R2->DONE edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_q      <= 16'h0000;
      key_q    <= 16'h0000;
      mode_q   <= 1'b0;
      Data_Out <= 16'h0000;
    end else begin
      if (accept) begin
        s_q    <= Data_In;
        key_q  <= Key;
        mode_q <= Mode;
      end else begin
        s_q <= s_next;
      end
      if (state == ST_R2) begin
        Data_Out <= s_next;
      end
    end
  end

endmodule

// File: tb/tb_saes_core_ctrl.sv
// tb_saes_core_ctrl
// Drives two controllers side by side: dut_a with registered round keys and
// dut_b with combinational round keys. Expected results are queued when a
// block is accepted. A negedge monitor pops and compares them whenever a
// result is handed over.
module tb_saes_core_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  in_valid;
  logic [1:0]  mode;
  logic [1:0]  out_ready;
  logic [15:0] data_in [2];
  logic [15:0] key [2];
  wire  [1:0]  in_ready;
  wire  [1:0]  out_valid;
  wire  [1:0]  busy;
  wire  [15:0] data_out [2];

  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  int total = 0;
  int bad = 0;
  int results_seen [2] = '{0, 0};

  saes_core_ctrl #(.KEY_REG(1'b1)) dut_a (
    .CLK       (clk),
    .RST       (rst[0]),
    .In_Valid  (in_valid[0]),
    .In_Ready  (in_ready[0]),
    .Mode      (mode[0]),
    .Data_In   (data_in[0]),
    .Key       (key[0]),
    .Out_Valid (out_valid[0]),
    .Out_Ready (out_ready[0]),
    .Data_Out  (data_out[0]),
    .Busy      (busy[0])
  );

  saes_core_ctrl #(.KEY_REG(1'b0)) dut_b (
    .CLK       (clk),
    .RST       (rst[1]),
    .In_Valid  (in_valid[1]),
    .In_Ready  (in_ready[1]),
    .Mode      (mode[1]),
    .Data_In   (data_in[1]),
    .Key       (key[1]),
    .Out_Valid (out_valid[1]),
    .Out_Ready (out_ready[1]),
    .Data_Out  (data_out[1]),
    .Busy      (busy[1])
  );

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, required);
    end
  endtask

  // Pops the oldest expected result for one DUT and compares it with Data_Out.
  task automatic scorePop(input int d);
    logic [15:0] expv;
    bit have;
    have = 1'b0;
    expv = 16'h0000;
    if (d == 0 && exp_q0.size() > 0) begin
      expv = exp_q0.pop_front();
      have = 1'b1;
    end else if (d == 1 && exp_q1.size() > 0) begin
      expv = exp_q1.pop_front();
      have = 1'b1;
    end
    results_seen[d]++;
    if (!have) begin
      total++;
      bad++;
      $display("[TB] FAIL result_unexpected dut%0d: got %h want none", d, data_out[d]);
    end else begin
      checkOutput($sformatf("result_dut%0d", d), {16'h0, data_out[d]}, {16'h0, expv});
    end
  endtask

  // Monitor: a result leaves on the next rising edge whenever valid and ready
  // are both high at the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d] === 1'b0 && out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
        scorePop(d);
      end
    end
  end

  // Offers one block and holds it until it is accepted. The expected result is
  // queued on the accept edge. Returns 1 time unit after that edge.
  task automatic applyStimulus(input int d, input logic m, input logic [15:0] din,
                               input logic [15:0] k, input logic [15:0] expv);
    int waited;
    waited = 0;
    mode[d]     = m;
    data_in[d]  = din;
    key[d]      = k;
    in_valid[d] = 1'b1;
    while (in_ready[d] !== 1'b1 && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (in_ready[d] !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout dut%0d: got in_ready=%b want 1", d, in_ready[d]);
    end else begin
      @(posedge clk);
      if (d == 0) exp_q0.push_back(expv);
      else        exp_q1.push_back(expv);
      #1;
    end
    in_valid[d] = 1'b0;
  endtask

  // Counts edges from the current point until Out_Valid is seen high.
  task automatic waitResult(input int d, input int lat, input string name);
    int cyc;
    cyc = 0;
    while (out_valid[d] !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput(name, cyc, lat);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 2'b11;
    in_valid   = 2'b00;
    mode       = 2'b00;
    out_ready  = 2'b11;
    data_in[0] = 16'h0000;
    data_in[1] = 16'h0000;
    key[0]     = 16'h0000;
    key[1]     = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset_out_valid_%0d", d), out_valid[d], 0);
      checkOutput($sformatf("reset_data_out_%0d", d), data_out[d], 16'h0000);
      checkOutput($sformatf("reset_in_ready_%0d", d), in_ready[d], 1);
      checkOutput($sformatf("reset_busy_%0d", d), busy[d], 0);
    end
    rst = 2'b00;

    $display("[TB] dut_a: encrypt and decrypt");
    applyStimulus(0, 1'b0, 16'hD728, 16'h4AF5, 16'h24EC);
    checkOutput("a_busy_after_accept", busy[0], 1);
    waitResult(0, 4, "a_enc_latency");
    checkOutput("a_k0", dut_a.rk0, 16'h4AF5);
    checkOutput("a_k1", dut_a.rk1, 16'hDD28);
    checkOutput("a_k2", dut_a.rk2, 16'h87AF);
    @(posedge clk); #1;
    checkOutput("a_idle_after_result", busy[0], 0);
    applyStimulus(0, 1'b1, 16'h24EC, 16'h4AF5, 16'hD728);
    waitResult(0, 4, "a_dec_latency");
    @(posedge clk); #1;

    $display("[TB] dut_a: backpressure");
    out_ready[0] = 1'b0;
    applyStimulus(0, 1'b0, 16'hD728, 16'h4AF5, 16'h24EC);
    waitResult(0, 4, "a_bp_latency");
    for (int i = 0; i < 10; i++) begin
      checkOutput("a_bp_out_valid", out_valid[0], 1);
      checkOutput("a_bp_data_out", data_out[0], 16'h24EC);
      checkOutput("a_bp_in_ready", in_ready[0], 0);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("a_bp_released", out_valid[0], 0);

    $display("[TB] dut_a: back-to-back");
    applyStimulus(0, 1'b0, 16'hD728, 16'h4AF5, 16'h24EC);
    applyStimulus(0, 1'b1, 16'h24EC, 16'h4AF5, 16'hD728);
    checkOutput("a_b2b_busy", busy[0], 1);
    checkOutput("a_b2b_out_valid_low", out_valid[0], 0);
    waitResult(0, 4, "a_b2b_second_latency");
    @(posedge clk); #1;
    checkOutput("a_b2b_out_valid_after", out_valid[0], 0);

    $display("[TB] dut_a: input ignored while busy");
    applyStimulus(0, 1'b0, 16'hD728, 16'h4AF5, 16'h24EC);
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_in[0]  = 16'hFFFF;
    key[0]      = 16'h0000;
    mode[0]     = 1'b1;
    in_valid[0] = 1'b1;
    checkOutput("a_ignore_in_ready", in_ready[0], 0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    waitResult(0, 1, "a_ignore_latency");
    @(posedge clk); #1;
    checkOutput("a_ignore_idle", busy[0], 0);

    $display("[TB] dut_a: reset mid-block");
    applyStimulus(0, 1'b0, 16'hD728, 16'h4AF5, 16'h24EC);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    void'(exp_q0.pop_back());
    #1;
    checkOutput("a_rst_out_valid", out_valid[0], 0);
    checkOutput("a_rst_data_out", data_out[0], 16'h0000);
    checkOutput("a_rst_busy", busy[0], 0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    checkOutput("a_rst_in_ready", in_ready[0], 1);
    applyStimulus(0, 1'b0, 16'hD728, 16'h4AF5, 16'h24EC);
    waitResult(0, 4, "a_post_rst_latency");
    @(posedge clk); #1;

    $display("[TB] dut_b: combinational round keys");
    applyStimulus(1, 1'b0, 16'hD728, 16'h4AF5, 16'h24EC);
    waitResult(1, 3, "b_enc_latency");
    checkOutput("b_k1", dut_b.rk1, 16'hDD28);
    checkOutput("b_k2", dut_b.rk2, 16'h87AF);
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 16'h24EC, 16'h4AF5, 16'hD728);
    waitResult(1, 3, "b_dec_latency");
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 16'hD728, 16'h4AF5, 16'h24EC);
    applyStimulus(1, 1'b1, 16'h24EC, 16'h4AF5, 16'hD728);
    checkOutput("b_b2b_busy", busy[1], 1);
    waitResult(1, 3, "b_b2b_second_latency");
    @(posedge clk); #1;
    checkOutput("b_b2b_out_valid_after", out_valid[1], 0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("a_results_seen", results_seen[0], 7);
    checkOutput("b_results_seen", results_seen[1], 4);
    checkOutput("a_queue_empty", exp_q0.size(), 0);
    checkOutput("b_queue_empty", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
